// File: rtl/ex_mem_register.sv
// ex_mem_register
//   Pipeline register between the execute and memory stages. It also owns the
//   architectural stack pointer (SP): it computes the push/pop stack address
//   and updates SP. It supports stall (hold) and flush (bubble) from the
//   hazard unit, and it keeps a sticky stack-fault flag.
//
// Optional feature macro: STACK_BOUNDS_CHECK_EN
//   When this macro is defined, a push at SP_LIMIT (overflow) or a pop at
//   SP_RESET (underflow) is suppressed and raises StackFault. When it is
//   undefined, SP wraps modulo 2^32 and only push+pop together is a fault.
//
// Parameters
//   SP_RESET  SP value after reset (top of stack, empty stack)
//   SP_LIMIT  lowest legal SP; a push at this value overflows
//
// Ports
//   Clk          in   1  rising-edge clock
//   Rst_n        in   1  asynchronous reset, active-low
//   Stall        in   1  hold the register and SP for this cycle
//   Flush        in   1  load a bubble this cycle (has priority over Stall)
//   ExValid      in   1  the execute stage presents a valid instruction
//   AluResult    in  16  ALU output / effective address
//   StoreData    in  16  data for a store or a push
//   Rdst         in   3  destination register index
//   Rsrc         in   3  source register index
//   MemRead      in   1  a load or pop reads memory
//   MemWrite     in   1  a store or push writes memory
//   Push         in   1  stack push
//   Pop          in   1  stack pop
//   WbCtrl       in   2  writeback control, passed through
//   FaultClear   in   1  clears the sticky stack fault
//   MemoryInput  out 76  {SpAddr[31:0], StoreData, AluResult, Rdst, Rsrc,
//                         MemRead, MemWrite, Push, Pop, WbCtrl}
//   OutValid     out  1  MemoryInput holds a valid instruction
//   SpValue      out 32  current SP
//   StackFault   out  1  sticky overflow / underflow / illegal push+pop flag

module ex_mem_register #(
  parameter logic [31:0] SP_RESET = 32'h000F_FFFF,
  parameter logic [31:0] SP_LIMIT = 32'h000F_F000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ExValid,
  input  logic [15:0] AluResult,
  input  logic [15:0] StoreData,
  input  logic [2:0]  Rdst,
  input  logic [2:0]  Rsrc,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Push,
  input  logic        Pop,
  input  logic [1:0]  WbCtrl,
  input  logic        FaultClear,
  output logic [75:0] MemoryInput,
  output logic        OutValid,
  output logic [31:0] SpValue,
  output logic        StackFault
);

`ifdef STACK_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } fault_state_t;

  logic [75:0]  r_mi;
  logic         r_valid;
  logic [31:0]  r_sp;
  fault_state_t r_state;
  fault_state_t w_state_next;

  logic         w_illegal;
  logic         w_overflow;
  logic         w_underflow;
  logic         w_suppress;
  logic         w_load_edge;
  logic         w_fault_event;
  logic [31:0]  w_sp_addr;
  logic [31:0]  w_sp_next;
  logic [3:0]   w_ctrl;
  logic [75:0]  w_mi_load;

  // Fault conditions are evaluated against the current SP. Bounds faults
  // apply only to a single push or a single pop. When the bounds check is
  // not built in, BoundsEn is 0 and both terms are constant 0.
  assign w_illegal   = Push & Pop;
  assign w_overflow  = BoundsEn && Push && !Pop && (r_sp == SP_LIMIT);
  assign w_underflow = BoundsEn && Pop && !Push && (r_sp == SP_RESET);
  assign w_suppress  = w_illegal | w_overflow | w_underflow;

  // Faults count only on edges that actually load an instruction.
  assign w_load_edge   = ExValid & ~Flush & ~Stall;
  assign w_fault_event = w_load_edge & w_suppress;

  // A push writes at the current SP and then decrements SP. A pop
  // pre-increments SP and reads at the new SP.
  always_comb begin
    w_sp_addr = r_sp;
    w_sp_next = r_sp;
    if (!w_suppress) begin
      if (Push) begin
        w_sp_next = r_sp - 32'd1;
      end else if (Pop) begin
        w_sp_addr = r_sp + 32'd1;
        w_sp_next = r_sp + 32'd1;
      end
    end
  end

  assign w_ctrl    = w_suppress ? '0 : {MemRead, MemWrite, Push, Pop};
  assign w_mi_load = {w_sp_addr, StoreData, AluResult, Rdst, Rsrc, w_ctrl, WbCtrl};

  // The pipeline register and SP. Flush has priority over Stall, and Stall
  // has priority over a load.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_mi    <= '0;
      r_valid <= 1'b0;
      r_sp    <= SP_RESET;
    end else if (Flush) begin
      r_mi    <= '0;
      r_valid <= 1'b0;
    end else if (Stall) begin
      r_mi    <= r_mi;
      r_valid <= r_valid;
    end else if (!ExValid) begin
      r_mi    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_mi    <= w_mi_load;
      r_valid <= 1'b1;
      r_sp    <= w_sp_next;
    end
  end

  // Fault FSM: state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fault FSM: next state. A new fault takes priority over FaultClear.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      NORMAL: if (w_fault_event) w_state_next = FAULT;
      FAULT:  if (FaultClear && !w_fault_event) w_state_next = NORMAL;
    endcase
  end

  // Fault FSM: output.
  always_comb begin
    StackFault = (r_state == FAULT);
  end

  assign MemoryInput = r_mi;
  assign OutValid    = r_valid;
  assign SpValue     = r_sp;

endmodule

// File: tb/tb_ex_mem_register.sv
module tb_ex_mem_register;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall, Flush, ExValid;
  logic [15:0] AluResult, StoreData;
  logic [2:0]  Rdst, Rsrc;
  logic        MemRead, MemWrite, Push, Pop;
  logic [1:0]  WbCtrl;
  logic        FaultClear;
  logic [75:0] MemoryInput;
  logic        OutValid;
  logic [31:0] SpValue;
  logic        StackFault;

  ex_mem_register #(
    .SP_RESET(32'h000F_FFFF),
    .SP_LIMIT(32'h000F_F000)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .ExValid(ExValid),
    .AluResult(AluResult), .StoreData(StoreData), .Rdst(Rdst), .Rsrc(Rsrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .Push(Push), .Pop(Pop),
    .WbCtrl(WbCtrl), .FaultClear(FaultClear), .MemoryInput(MemoryInput),
    .OutValid(OutValid), .SpValue(SpValue), .StackFault(StackFault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [75:0] mi;
    logic        ov;
    logic [31:0] sp;
    logic        sf;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state
  logic [31:0] m_sp = 32'h000F_FFFF;
  logic [75:0] m_mi = '0;
  logic        m_ov = 1'b0;
  logic        m_sf = 1'b0;

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, push the expectation,
  // clock, then pop and compare.
  task automatic cyc(input string tag, input logic st, input logic fl, input logic ev,
                     input logic [15:0] alu, input logic [15:0] sd,
                     input logic [2:0] rd, input logic [2:0] rs,
                     input logic mr, input logic mw, input logic pu, input logic po,
                     input logic [1:0] wb, input logic fc);
    logic        bad;
    logic        newf;
    logic [31:0] addr;
    logic [31:0] nsp;
    logic [3:0]  ctl;
    exp_t        e;
    exp_t        g;
    Stall = st; Flush = fl; ExValid = ev; AluResult = alu; StoreData = sd;
    Rdst = rd; Rsrc = rs; MemRead = mr; MemWrite = mw; Push = pu; Pop = po;
    WbCtrl = wb; FaultClear = fc;
    newf = 1'b0;
    if (fl) begin
      m_mi = '0; m_ov = 1'b0;
    end else if (!st) begin
      if (!ev) begin
        m_mi = '0; m_ov = 1'b0;
      end else begin
        bad = pu && po;
`ifdef STACK_BOUNDS_CHECK_EN
        if (pu && !po && m_sp == 32'h000F_F000) bad = 1'b1;
        if (po && !pu && m_sp == 32'h000F_FFFF) bad = 1'b1;
`endif
        addr = m_sp;
        nsp  = m_sp;
        if (!bad && pu) nsp = m_sp - 32'd1;
        if (!bad && po) begin addr = m_sp + 32'd1; nsp = addr; end
        ctl  = bad ? 4'b0000 : {mr, mw, pu, po};
        m_mi = {addr, sd, alu, rd, rs, ctl, wb};
        m_ov = 1'b1;
        m_sp = nsp;
        newf = bad;
      end
    end
    if (newf) m_sf = 1'b1;
    else if (fc) m_sf = 1'b0;
    e.mi = m_mi; e.ov = m_ov; e.sp = m_sp; e.sf = m_sf;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      g = sb.pop_front();
      chk({tag, ".mi"}, MemoryInput, g.mi);
      chk({tag, ".ov"}, {75'd0, OutValid}, {75'd0, g.ov});
      chk({tag, ".sp"}, {44'd0, SpValue}, {44'd0, g.sp});
      chk({tag, ".sf"}, {75'd0, StackFault}, {75'd0, g.sf});
    end
  endtask

  initial begin
    logic [75:0] frozen_mi;
    logic [31:0] frozen_sp;
    int unsigned guard;
    Rst_n = 1'b0;
    {Stall, Flush, ExValid, MemRead, MemWrite, Push, Pop, FaultClear} = '0;
    AluResult = '0; StoreData = '0; Rdst = '0; Rsrc = '0; WbCtrl = '0;
    @(posedge Clk);
    #3 Rst_n = 1'b1;
    #1;
    chk("rst.sp", {44'd0, SpValue}, {44'd0, 32'h000F_FFFF});
    chk("rst.ov", {75'd0, OutValid}, 76'd0);
    chk("rst.mi", MemoryInput, 76'd0);
    chk("rst.sf", {75'd0, StackFault}, 76'd0);
    @(negedge Clk);

    // Push then pop
    cyc("push", 0, 0, 1, 16'h0000, 16'h1234, 3'd1, 3'd2, 0, 1, 1, 0, 2'b01, 0);
    chk("push.spaddr", {44'd0, MemoryInput[75:44]}, {44'd0, 32'h000F_FFFF});
    chk("push.data", {60'd0, MemoryInput[43:28]}, {60'd0, 16'h1234});
    chk("push.bits43", {74'd0, MemoryInput[4:3]}, {74'd0, 2'b11});
    chk("push.spnext", {44'd0, SpValue}, {44'd0, 32'h000F_FFFE});
    cyc("pop", 0, 0, 1, 16'h0000, 16'h0000, 3'd4, 3'd0, 1, 0, 0, 1, 2'b10, 0);
    chk("pop.spaddr", {44'd0, MemoryInput[75:44]}, {44'd0, 32'h000F_FFFF});
    chk("pop.bits52", {72'd0, MemoryInput[5:2]}, {72'd0, 4'b1001});

    // Load, stall with changing inputs, then stall+flush
    cyc("load", 0, 0, 1, 16'h00A5, 16'h5A5A, 3'd3, 3'd6, 0, 0, 0, 0, 2'b11, 0);
    frozen_mi = MemoryInput;
    frozen_sp = SpValue;
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 1, 0, 1, 16'($urandom), 16'($urandom), 3'(i), 3'(i + 1),
          1'($urandom), 1'($urandom), 1'(i == 0), 1'(i == 1), 2'(i), 0);
      chk("stall.frozen_mi", MemoryInput, frozen_mi);
      chk("stall.frozen_sp", {44'd0, SpValue}, {44'd0, frozen_sp});
    end
    cyc("stallflush", 1, 1, 1, 16'hFFFF, 16'hFFFF, 3'd7, 3'd7, 1, 1, 1, 0, 2'b11, 0);
    chk("stallflush.ov", {75'd0, OutValid}, 76'd0);
    cyc("store", 0, 0, 1, 16'h0100, 16'hBEEF, 3'd0, 3'd5, 0, 1, 0, 0, 2'b00, 0);
    cyc("bubble", 0, 0, 0, 16'h1111, 16'h2222, 3'd1, 3'd1, 1, 0, 0, 0, 2'b01, 0);

    // Pop at the reset SP, then clear
    cyc("pop_top", 0, 0, 1, 16'h0042, 16'h0000, 3'd2, 3'd0, 1, 0, 0, 1, 2'b10, 0);
`ifdef STACK_BOUNDS_CHECK_EN
    chk("pop_top.bits52", {72'd0, MemoryInput[5:2]}, 76'd0);
    chk("pop_top.sf", {75'd0, StackFault}, 76'd1);
`else
    chk("pop_top.sp", {44'd0, SpValue}, {44'd0, 32'h0010_0000});
`endif
    cyc("clear", 0, 0, 0, 16'h0, 16'h0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 1);
    chk("clear.sf", {75'd0, StackFault}, 76'd0);

    // Descend to SP_LIMIT
    guard = 0;
    while (m_sp != 32'h000F_F000 && guard < 5000) begin
      cyc("descend", 0, 0, 1, 16'(guard), 16'(guard ^ 16'hA5A5), 3'd0, 3'd1, 0, 1, 1, 0, 2'b00, 0);
      guard++;
    end
    chk("descend.sp", {44'd0, SpValue}, {44'd0, 32'h000F_F000});
    cyc("push_limit", 0, 0, 1, 16'h0777, 16'hCAFE, 3'd5, 3'd2, 0, 1, 1, 0, 2'b01, 0);
`ifdef STACK_BOUNDS_CHECK_EN
    chk("push_limit.sp", {44'd0, SpValue}, {44'd0, 32'h000F_F000});
    chk("push_limit.sf", {75'd0, StackFault}, 76'd1);
`else
    chk("push_limit.sp", {44'd0, SpValue}, {44'd0, 32'h000F_EFFF});
    chk("push_limit.sf", {75'd0, StackFault}, 76'd0);
`endif
    cyc("clear2", 0, 0, 0, 16'h0, 16'h0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 1);

    // Illegal push+pop; a new fault beats FaultClear
    frozen_sp = SpValue;
    cyc("pushpop", 0, 0, 1, 16'h0303, 16'h0404, 3'd6, 3'd3, 1, 1, 1, 1, 2'b10, 1);
    chk("pushpop.sp", {44'd0, SpValue}, {44'd0, frozen_sp});
    chk("pushpop.bits52", {72'd0, MemoryInput[5:2]}, 76'd0);
    chk("pushpop.sf", {75'd0, StackFault}, 76'd1);
    cyc("stall_pushpop", 1, 0, 1, 16'h0, 16'h0, 3'd0, 3'd0, 1, 1, 1, 1, 2'b00, 0);
    cyc("clear3", 0, 0, 0, 16'h0, 16'h0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 1);
    cyc("flush_pushpop", 0, 1, 1, 16'h0, 16'h0, 3'd0, 3'd0, 0, 0, 1, 1, 2'b00, 0);
    cyc("pushpop2", 0, 0, 1, 16'h0909, 16'h0808, 3'd1, 3'd1, 0, 0, 1, 1, 2'b11, 0);

    // Asynchronous reset in the middle of a cycle
    #2 Rst_n = 1'b0;
    #1;
    chk("async.mi", MemoryInput, 76'd0);
    chk("async.ov", {75'd0, OutValid}, 76'd0);
    chk("async.sp", {44'd0, SpValue}, {44'd0, 32'h000F_FFFF});
    chk("async.sf", {75'd0, StackFault}, 76'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
